// File: rtl/memory_island_bank_arbiter_pkg.sv
// Shared types and constants for the memory island bank arbiter.
// Holds the response-pipeline tag and the conflict counter width.
package memory_island_pkg;

  localparam int ARB_CNT_W = 16;
  // Tag index is sized for the largest supported requester count (256).
  localparam int ARB_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [ARB_IDX_W-1:0] index;
  } bank_rsp_tag_t;

endpackage

// File: rtl/memory_island_bank_arbiter_if.sv
// Requester-side bus of the bank arbiter: per-requester request fields,
// grant, and the one-hot response strobe with shared read data.
interface memory_island_bank_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64
);
  logic [NumReq-1:0]             req_valid_i;
  logic [NumReq-1:0]             req_ready_o;
  logic [NumReq*AddrWidth-1:0]   req_addr_i;
  logic [NumReq-1:0]             req_we_i;
  logic [NumReq*DataWidth/8-1:0] req_be_i;
  logic [NumReq*DataWidth-1:0]   req_wdata_i;
  logic [NumReq-1:0]             rsp_valid_o;
  logic [DataWidth-1:0]          rsp_rdata_o;

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/memory_island_bank_arbiter_rr_arb_pick.sv
// Combinational round-robin pick: first valid index at or above ptr,
// wrapping to the lowest valid index when nothing at or above ptr is valid.
module rr_arb_pick #(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]         valid,
  input  logic [$clog2(NumReq)-1:0] ptr,
  output logic [NumReq-1:0]         onehot,
  output logic [$clog2(NumReq)-1:0] index,
  output logic                      any
);
  localparam int IdxW = $clog2(NumReq);

  logic            hi_found, lo_found;
  logic [IdxW-1:0] hi_idx, lo_idx;

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value held over and no latch is inferred.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = 0; j < NumReq; j++) begin
      if (valid[j] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IdxW'(j);
      end
      if (valid[j] && !hi_found && (IdxW'(j) >= ptr)) begin
        hi_found = 1'b1;
        hi_idx   = IdxW'(j);
      end
    end
  end

  assign any   = |valid;
  assign index = hi_found ? hi_idx : lo_idx;

  always_comb begin
    onehot = '0;
    for (int j = 0; j < NumReq; j++) begin
      onehot[j] = any && (index == IdxW'(j));
    end
  end
endmodule

// File: rtl/memory_island_bank_arbiter.sv
// Round-robin arbiter sharing one single-ported SRAM bank among NumReq requesters,
// with a fixed-latency response pipeline. Optional MEM_ISLAND_ARB_STATS_EN adds conflict counters.
module memory_island_bank_arbiter
  import memory_island_pkg::*;
#(
  parameter int NumReq      = 4,
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 64,
  parameter int BankLatency = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  memory_island_bank_arbiter_if.slave  req_if,
  output logic                         bank_req_o,
  output logic                         bank_we_o,
  output logic [AddrWidth-1:0]         bank_addr_o,
  output logic [DataWidth/8-1:0]       bank_be_o,
  output logic [DataWidth-1:0]         bank_wdata_o,
  input  logic [DataWidth-1:0]         bank_rdata_i
`ifdef MEM_ISLAND_ARB_STATS_EN
  ,
  output logic [NumReq*ARB_CNT_W-1:0]  conflict_cnt_o
`endif
);
  localparam int IdxW = $clog2(NumReq);
  localparam int BeW  = DataWidth/8;

  logic [IdxW-1:0]   rr_q, rr_d;
  logic [IdxW-1:0]   win_idx;
  logic [NumReq-1:0] win_onehot;
  logic [NumReq-1:0] ready;
  logic              win_any;
  logic              grant;
  bank_rsp_tag_t     pipe_q [BankLatency];
  logic [NumReq-1:0] rsp_valid;

  rr_arb_pick #(.NumReq(NumReq)) u_pick (
    .valid  (req_if.req_valid_i),
    .ptr    (rr_q),
    .onehot (win_onehot),
    .index  (win_idx),
    .any    (win_any)
  );

  // The bank mux follows the inputs even in reset; only the grant is held off.
  assign grant              = win_any & ~rst_i;
  assign ready              = win_onehot & {NumReq{~rst_i}};
  assign req_if.req_ready_o = ready;
  assign bank_req_o         = |req_if.req_valid_i;

  always_comb begin
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_be_o    = '0;
    bank_wdata_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (win_onehot[i]) begin
        bank_we_o    = req_if.req_we_i[i];
        bank_addr_o  = req_if.req_addr_i[i*AddrWidth +: AddrWidth];
        bank_be_o    = req_if.req_be_i[i*BeW +: BeW];
        bank_wdata_o = req_if.req_wdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  assign rr_d = (win_idx == IdxW'(NumReq-1)) ? '0 : win_idx + IdxW'(1);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (grant) begin
      rr_q <= rr_d;
    end
  end

  // NOTE: the tag pipeline is control state and must be reset so in-flight
  // responses are dropped; wide data arrays elsewhere would not need this.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BankLatency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: grant, index: ARB_IDX_W'(win_idx)};
      for (int i = 1; i < BankLatency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NumReq; i++) begin
      rsp_valid[i] = pipe_q[BankLatency-1].valid &&
                     (pipe_q[BankLatency-1].index == ARB_IDX_W'(i));
    end
  end

  assign req_if.rsp_valid_o = rsp_valid;
  assign req_if.rsp_rdata_o = bank_rdata_i;

`ifdef MEM_ISLAND_ARB_STATS_EN
  logic [ARB_CNT_W-1:0] cnt_q [NumReq];

  // Cycles a requester waited while another one held the bank, saturating.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (req_if.req_valid_i[i] && !ready[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + ARB_CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_cnt
    assign conflict_cnt_o[g*ARB_CNT_W +: ARB_CNT_W] = cnt_q[g];
  end
`endif
endmodule

// File: tb/tb_memory_island_bank_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a queue-based round-robin/response model.
module tb_memory_island_bank_arbiter;
  import memory_island_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int BW  = DW/8;
  localparam int LAT = 2;

  typedef struct {
    int due;
    int idx;
    bit we;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_island_bank_arbiter_if #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

  logic          bank_req, bank_we;
  logic [AW-1:0] bank_addr;
  logic [BW-1:0] bank_be;
  logic [DW-1:0] bank_wdata, bank_rdata;
`ifdef MEM_ISLAND_ARB_STATS_EN
  logic [N*ARB_CNT_W-1:0] conflict_cnt;
`endif

  memory_island_bank_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .BankLatency(LAT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_if       (bus),
    .bank_req_o   (bank_req),
    .bank_we_o    (bank_we),
    .bank_addr_o  (bank_addr),
    .bank_be_o    (bank_be),
    .bank_wdata_o (bank_wdata),
    .bank_rdata_i (bank_rdata)
`ifdef MEM_ISLAND_ARB_STATS_EN
    ,
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side stimulus
  logic [N-1:0]  f_valid;
  logic [AW-1:0] f_addr  [N];
  logic          f_we    [N];
  logic [BW-1:0] f_be    [N];
  logic [DW-1:0] f_wdata [N];

  // Reference model state
  int    m_ptr = 0;
  int    cyc   = 0;
  int    last_win = -1;
  int    m_cnt [N];
  pend_t pend [$];

  // Values sampled at the last negedge
  logic [N-1:0]  s_ready, s_rsp;
  logic          s_breq, s_we;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_be;
  logic [DW-1:0] s_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // First valid requester at or above p, searching upward with wrap.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic pack();
    bus.req_valid_i = f_valid;
    for (int i = 0; i < N; i++) begin
      bus.req_addr_i[i*AW +: AW]  = f_addr[i];
      bus.req_we_i[i]             = f_we[i];
      bus.req_be_i[i*BW +: BW]    = f_be[i];
      bus.req_wdata_i[i*DW +: DW] = f_wdata[i];
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic we,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
    f_addr[i]  = a;
    f_we[i]    = we;
    f_be[i]    = be;
    f_wdata[i] = wd;
  endtask

  task automatic rand_req(input int i);
    set_req(i, $urandom, 1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom});
  endtask

  // One clock cycle: check all outputs at negedge, then advance the model.
  task automatic cycle();
    int           wb, w;
    logic [N-1:0] v, er, ers;
    bit           rd;
    bank_rdata = {$urandom, $urandom};
    @(negedge clk);
    v  = bus.req_valid_i;
    wb = pick(v, m_ptr);
    w  = rst ? -1 : wb;
    s_ready = bus.req_ready_o;
    s_rsp   = bus.rsp_valid_o;
    s_breq  = bank_req;
    s_we    = bank_we;
    s_addr  = bank_addr;
    s_be    = bank_be;
    s_wdata = bank_wdata;

    er = '0;
    if (w >= 0) er[w] = 1'b1;
    check("ready", s_ready, er);
    check("bank_req", s_breq, |v);
    check("bank_we", s_we, (wb >= 0) ? f_we[wb] : 1'b0);
    check("bank_addr", s_addr, (wb >= 0) ? f_addr[wb] : '0);
    check("bank_be", s_be, (wb >= 0) ? f_be[wb] : '0);
    check("bank_wdata", s_wdata, (wb >= 0) ? f_wdata[wb] : '0);

    ers = '0;
    rd  = 1'b0;
    if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
      ers[pend[0].idx] = 1'b1;
      rd = !pend[0].we;
      void'(pend.pop_front());
    end
    check("rsp_valid", s_rsp, ers);
    if (rd) check("rsp_rdata", bus.rsp_rdata_o, bank_rdata);

`ifdef MEM_ISLAND_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      check("conflict_cnt", conflict_cnt[i*ARB_CNT_W +: ARB_CNT_W], 64'(m_cnt[i]));
      if (!rst && v[i] && w != i && m_cnt[i] < 65535) m_cnt[i]++;
    end
`endif

    last_win = w;
    if (w >= 0) begin
      pend.push_back('{due: cyc + LAT, idx: w, we: f_we[w]});
      m_ptr = (w + 1) % N;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    pend.delete();
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  int wait_cnt [N];
  int max_wait = 0;

  initial begin
    f_valid    = '0;
    bank_rdata = '0;
    for (int i = 0; i < N; i++) begin
      set_req(i, '0, 1'b0, '0, '0);
      m_cnt[i]    = 0;
      wait_cnt[i] = 0;
    end
    pack();

    // Reset state, and ready forced low while valids are present in reset
    do_reset(2);
    check("rst_rsp", s_rsp, '0);
    check("rst_bank_req_idle", s_breq, 1'b0);
    rst = 1'b1;
    f_valid = '1;
    pack();
    cycle();
    check("rst_ready_forced", s_ready, '0);
    check("rst_bank_req_follows", s_breq, 1'b1);
    f_valid = '0;
    pack();
    rst = 1'b0;

    // Single read from requester 2 at 0x10
    set_req(2, 32'h10, 1'b0, '1, '0);
    f_valid = 4'b0100;
    pack();
    cycle();
    check("t1_bank_req", s_breq, 1'b1);
    check("t1_bank_addr", s_addr, 32'h10);
    f_valid = '0;
    pack();
    repeat (LAT) cycle();
    check("t1_rsp", s_rsp, 4'b0100);

    // All four valid from reset: 0,1,2,3,0,1,2,3
    do_reset(1);
    for (int i = 0; i < N; i++) rand_req(i);
    f_valid = '1;
    pack();
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] e;
      cycle();
      e = '0;
      e[i % N] = 1'b1;
      check("t2_rr_seq", s_ready, e);
    end

    // Move pointer to 2, then requesters 1 and 3: expect 3,1,3
    f_valid = 4'b0010;
    pack();
    cycle();
    f_valid = 4'b1010;
    pack();
    cycle();
    check("t3_first", s_ready, 4'b1000);
    cycle();
    check("t3_second", s_ready, 4'b0010);
    cycle();
    check("t3_third", s_ready, 4'b1000);
    f_valid = '0;
    pack();
    repeat (LAT) cycle();

    // Write from requester 0 with byte enables 0x0F
    set_req(0, 32'h40, 1'b1, 8'h0F, 64'hDEAD);
    f_valid = 4'b0001;
    pack();
    cycle();
    check("t4_bank_we", s_we, 1'b1);
    check("t4_bank_be", s_be, 8'h0F);
    check("t4_bank_wdata", s_wdata, 64'hDEAD);
    f_valid = '0;
    pack();
    repeat (LAT) cycle();
    check("t4_ack", s_rsp, 4'b0001);

    // Reset one cycle after a read grant drops the response
    set_req(2, 32'h80, 1'b0, '1, '0);
    f_valid = 4'b0100;
    pack();
    cycle();
    f_valid = '0;
    pack();
    do_reset(2);
    check("t5_dropped", s_rsp, '0);
    repeat (LAT) cycle();
    check("t5_no_late_rsp", s_rsp, '0);
    for (int i = 1; i < N; i++) rand_req(i);
    f_valid = 4'b1110;
    pack();
    cycle();
    check("t5_lowest_wins", s_ready, 4'b0010);
    f_valid = '0;
    pack();
    repeat (LAT) cycle();

    // Randomized traffic; a requester holds its request until granted
    last_win = -1;
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        do_reset(2);
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (!f_valid[i] || last_win == i) begin
          f_valid[i] = ($urandom_range(0, 99) < 45);
          rand_req(i);
        end
      end
      pack();
      cycle();
      for (int i = 0; i < N; i++) begin
        if (f_valid[i] && last_win != i) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end else begin
          wait_cnt[i] = 0;
        end
      end
    end
    check("fair_wait_bound", 64'(max_wait <= N - 1), 64'd1);

    f_valid = '0;
    pack();
    repeat (LAT + 1) cycle();
    check("drain_empty", 64'(pend.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
